sha256_main_block: RTL and testbench

SHA-256 compression-round datapath for the ASIC hash core. It holds the eight working variables a..h plus seven scratch words in a 16×32 register file. It executes one SHA-256 round per command cycle, using an externally supplied message word W and a round index that selects the internal K constant. The top-level controller sequences loads, 64 rounds and readback through address-style ports.

---
 rtl/sha256_pkg.sv | 79 +++++++
 rtl/sha256_round_logic.sv | 38 +++
 rtl/sha256_main_block.sv | 109 ++++++++++
 tb/tb_sha256_main_block.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// ---------------------------------------------------------------------------
// sha256_pkg
// Shared definitions for the SHA-256 compression-round datapath:
//   - register-file addresses of the working variables a..h and of the
//     round command (address 0)
//   - the 64-entry round-constant table K[0..63]
//   - the four SHA-256 round functions (Sigma0, Sigma1, Ch, Maj)
//   - a packed struct bundling the eight working variables
// ---------------------------------------------------------------------------
package sha256_pkg;

  // Command / register-file addresses
  localparam logic [3:0] ADDR_ROUND = 4'd0;
  localparam logic [3:0] ADDR_A     = 4'd1;
  localparam logic [3:0] ADDR_B     = 4'd2;
  localparam logic [3:0] ADDR_C     = 4'd3;
  localparam logic [3:0] ADDR_D     = 4'd4;
  localparam logic [3:0] ADDR_E     = 4'd5;
  localparam logic [3:0] ADDR_F     = 4'd6;
  localparam logic [3:0] ADDR_G     = 4'd7;
  localparam logic [3:0] ADDR_H     = 4'd8;

  // The eight working variables, a in the most significant slot
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } work_vars_t;

  // SHA-256 round constants K[0..63]
  localparam logic [31:0] K_TABLE [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Sigma0(a) = ROTR2 ^ ROTR13 ^ ROTR22
  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  // Sigma1(e) = ROTR6 ^ ROTR11 ^ ROTR25
  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_round_logic.sv
// ---------------------------------------------------------------------------
// sha256_round_logic
// Purely combinational SHA-256 round: maps the current working variables,
// the round constant K[t] and the message word W[t] to the next working
// variables (new a and e, the rest shifted down by one position).
// Ports:
//   i_vars  in  work_vars_t  current a..h
//   i_k     in  32           round constant K[t]
//   i_w     in  32           message schedule word W[t]
//   o_vars  out work_vars_t  next a..h
// ---------------------------------------------------------------------------
module sha256_round_logic
  import sha256_pkg::*;
(
  input  work_vars_t  i_vars,
  input  logic [31:0] i_k,
  input  logic [31:0] i_w,
  output work_vars_t  o_vars
);

  logic [31:0] w_t1;
  logic [31:0] w_t2;

  // All additions wrap modulo 2^32 through the 32-bit result width
  assign w_t1 = i_vars.h + big_sigma1(i_vars.e) + ch(i_vars.e, i_vars.f, i_vars.g)
              + i_k + i_w;
  assign w_t2 = big_sigma0(i_vars.a) + maj(i_vars.a, i_vars.b, i_vars.c);

  assign o_vars.a = w_t1 + w_t2;
  assign o_vars.b = i_vars.a;
  assign o_vars.c = i_vars.b;
  assign o_vars.d = i_vars.c;
  assign o_vars.e = i_vars.d + w_t1;
  assign o_vars.f = i_vars.e;
  assign o_vars.g = i_vars.f;
  assign o_vars.h = i_vars.g;

endmodule

// File: rtl/sha256_main_block.sv
// ---------------------------------------------------------------------------
// sha256_main_block
// SHA-256 compression-round datapath. A 16-word register file holds the
// working variables a..h at addresses 1..8 and scratch words at 9..15;
// address 0 is not storage and always reads 0.
// Every rising clock edge executes exactly one command chosen by
// mem_in_addr: 1..15 loads in_var into that word, 0 runs one round using
// K[k_num] and in_w (scratch words hold).
// Ports:
//   clk           in   1   system clock
//   rst           in   1   asynchronous active-high reset, clears all words
//   in_var        in  32   load data
//   in_w          in  32   message word W[t]
//   k_num         in   6   round index t
//   mem_in_addr   in   4   command / write address
//   mem_out_addr  in   4   readback address
//   en_mem_out    in   1   readback enable (0 forces out_var to 0)
//   out_var       out 32   readback data
// Configuration macro SHA256_MAIN_BLOCK_OUT_REG_EN: when defined, out_var
// is registered (one clock read latency, 0 after reset); otherwise it is a
// combinational read of the current register contents.
// ---------------------------------------------------------------------------
module sha256_main_block
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_var,
  input  logic [31:0] in_w,
  input  logic [5:0]  k_num,
  input  logic [3:0]  mem_in_addr,
  input  logic [3:0]  mem_out_addr,
  input  logic        en_mem_out,
  output logic [31:0] out_var
);

  // Word 0 has no storage behind it
  logic [31:0] r_mem [1:15];
  logic [31:0] w_mem_view [0:15];
  logic [31:0] w_rd_data;
  work_vars_t  w_cur;
  work_vars_t  w_next;

  assign w_mem_view[0] = 32'h0000_0000;
  for (genvar gi = 1; gi < 16; gi++) begin : g_view
    assign w_mem_view[gi] = r_mem[gi];
  end

  assign w_rd_data = w_mem_view[mem_out_addr];

  assign w_cur.a = r_mem[ADDR_A];
  assign w_cur.b = r_mem[ADDR_B];
  assign w_cur.c = r_mem[ADDR_C];
  assign w_cur.d = r_mem[ADDR_D];
  assign w_cur.e = r_mem[ADDR_E];
  assign w_cur.f = r_mem[ADDR_F];
  assign w_cur.g = r_mem[ADDR_G];
  assign w_cur.h = r_mem[ADDR_H];

  sha256_round_logic u_round (
    .i_vars (w_cur),
    .i_k    (K_TABLE[k_num]),
    .i_w    (in_w),
    .o_vars (w_next)
  );

  // Register file: either one round update of a..h or a single-word load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < 16; i++) begin
        r_mem[i] <= 32'h0000_0000;
      end
    end else if (mem_in_addr == ADDR_ROUND) begin
      r_mem[ADDR_A] <= w_next.a;
      r_mem[ADDR_B] <= w_next.b;
      r_mem[ADDR_C] <= w_next.c;
      r_mem[ADDR_D] <= w_next.d;
      r_mem[ADDR_E] <= w_next.e;
      r_mem[ADDR_F] <= w_next.f;
      r_mem[ADDR_G] <= w_next.g;
      r_mem[ADDR_H] <= w_next.h;
    end else begin
      for (int i = 1; i < 16; i++) begin
        if (mem_in_addr == 4'(i)) begin
          r_mem[i] <= in_var;
        end
      end
    end
  end

`ifdef SHA256_MAIN_BLOCK_OUT_REG_EN
  logic [31:0] r_out;

  // Registered readback: one clock of latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out <= 32'h0000_0000;
    end else begin
      r_out <= en_mem_out ? w_rd_data : 32'h0000_0000;
    end
  end

  assign out_var = r_out;
`else
  // Combinational readback: a same-cycle write is seen only after the edge
  assign out_var = en_mem_out ? w_rd_data : 32'h0000_0000;
`endif

endmodule

// File: tb/tb_sha256_main_block.sv
// ---------------------------------------------------------------------------
// tb_sha256_main_block
// Directed self-checking bench for sha256_main_block (default build with a
// combinational readback). Inputs change on the falling clock edge; reads
// are sampled shortly after the falling edge, well away from the rising
// edge. Between commands the bench keeps loading 0 into scratch word 15,
// since every clock edge executes some command.
// ---------------------------------------------------------------------------
module tb_sha256_main_block;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_var;
  logic [31:0] in_w;
  logic [5:0]  k_num;
  logic [3:0]  mem_in_addr;
  logic [3:0]  mem_out_addr;
  logic        en_mem_out;
  logic [31:0] out_var;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] h0 [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  sha256_main_block dut (
    .clk          (clk),
    .rst          (rst),
    .in_var       (in_var),
    .in_w         (in_w),
    .k_num        (k_num),
    .mem_in_addr  (mem_in_addr),
    .mem_out_addr (mem_out_addr),
    .en_mem_out   (en_mem_out),
    .out_var      (out_var)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Read one word after the falling edge and compare
  task automatic rd(input logic [3:0] addr, input logic [31:0] exp, input string tag);
    @(negedge clk);
    en_mem_out   = 1'b1;
    mem_out_addr = addr;
    #1;
    check(tag, out_var, exp);
  endtask

  // Issue one command on the next rising edge, then return to idle
  task automatic cmd(input logic [3:0] addr, input logic [31:0] v,
                     input logic [31:0] w, input logic [5:0] k);
    @(negedge clk);
    mem_in_addr = addr;
    in_var      = v;
    in_w        = w;
    k_num       = k;
    @(posedge clk);
    #1;
    mem_in_addr = 4'd15;
    in_var      = 32'h0;
  endtask

  initial begin
    rst          = 1'b1;
    in_var       = 32'h0;
    in_w         = 32'h0;
    k_num        = 6'd0;
    mem_in_addr  = 4'd15;
    mem_out_addr = 4'd0;
    en_mem_out   = 1'b1;

    // Reset: every address reads 0 while rst is held
    #12;
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), 32'h0, $sformatf("reset_addr%0d", i));
    end
    @(negedge clk);
    rst = 1'b0;

    // Load / readback
    cmd(4'd1, 32'h6a09e667, 32'h0, 6'd0);
    cmd(4'd2, 32'hbb67ae85, 32'h0, 6'd0);
    cmd(4'd3, 32'h3c6ef372, 32'h0, 6'd0);
    rd(4'd1, 32'h6a09e667, "load_a");
    rd(4'd2, 32'hbb67ae85, "load_b");
    rd(4'd3, 32'h3c6ef372, "load_c");
    @(negedge clk);
    en_mem_out   = 1'b0;
    mem_out_addr = 4'd1;
    #1;
    check("read_disabled", out_var, 32'h0);

    // Zero-state round with K[0] and W=02000000
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmd(4'd0, 32'h0, 32'h02000000, 6'd0);
    rd(4'd1, 32'h448a2f98, "zero_round_a");
    rd(4'd5, 32'h448a2f98, "zero_round_e");
    rd(4'd2, 32'h0, "zero_round_b");
    rd(4'd4, 32'h0, "zero_round_d");
    rd(4'd6, 32'h0, "zero_round_f");
    rd(4'd8, 32'h0, "zero_round_h");

    // "abc" block, round 0 from the initial hash value
    for (int i = 0; i < 8; i++) begin
      cmd(4'(i + 1), h0[i], 32'h0, 6'd0);
    end
    cmd(4'd9, 32'h12345678, 32'h0, 6'd0);
    cmd(4'd0, 32'h0, 32'h61626380, 6'd0);
    rd(4'd1, 32'h5d6aebcd, "abc_r0_a");
    rd(4'd2, 32'h6a09e667, "abc_r0_b");
    rd(4'd3, 32'hbb67ae85, "abc_r0_c");
    rd(4'd4, 32'h3c6ef372, "abc_r0_d");
    rd(4'd5, 32'hfa2a4622, "abc_r0_e");
    rd(4'd6, 32'h510e527f, "abc_r0_f");
    rd(4'd7, 32'h9b05688c, "abc_r0_g");
    rd(4'd8, 32'h1f83d9ab, "abc_r0_h");
    rd(4'd9, 32'h12345678, "scratch_hold");
    rd(4'd0, 32'h0, "addr0_zero");

    // "abc" block, round 1 (W[1]=0, K[1])
    cmd(4'd0, 32'h0, 32'h0, 6'd1);
    rd(4'd1, 32'h5a6ad9ad, "abc_r1_a");
    rd(4'd4, 32'hbb67ae85, "abc_r1_d");
    rd(4'd5, 32'h78ce7989, "abc_r1_e");
    rd(4'd8, 32'h9b05688c, "abc_r1_h");
    rd(4'd9, 32'h12345678, "scratch_hold_r1");

    // Read and write the same address in one cycle
    @(negedge clk);
    mem_in_addr  = 4'd2;
    in_var       = 32'hcafef00d;
    mem_out_addr = 4'd2;
    en_mem_out   = 1'b1;
    #1;
    check("rw_same_old", out_var, 32'h5d6aebcd);
    @(posedge clk);
    #1;
    mem_in_addr = 4'd15;
    in_var      = 32'h0;
    check("rw_same_new", out_var, 32'hcafef00d);

    // Asynchronous reset mid-sequence, observed before any clock edge
    @(negedge clk);
    mem_out_addr = 4'd1;
    #1;
    check("pre_reset_a", out_var, 32'h5a6ad9ad);
    #1;
    rst = 1'b1;
    #1;
    check("async_reset_a", out_var, 32'h0);
    for (int i = 2; i < 10; i++) begin
      rd(4'(i), 32'h0, $sformatf("async_reset_addr%0d", i));
    end
    @(negedge clk);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
